// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Purpose : shared constants and the buffered-store entry type for the
//           store_buffer block and its sb_match sub-module.
// Contents:
//   WORD_SHIFT  - byte-to-word address shift (32-bit words)
//   DMEM_WORDS  - depth of the attached data memory in words
//   SB_AW       - address width the entry type is laid out for
//   sb_entry_t  - {word address, data, valid}
//   sb_word_addr- helper that extracts the word address from a byte address
// -----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int WORD_SHIFT = 2;
    localparam int DMEM_WORDS = 32;
    localparam int SB_AW      = 32;

    typedef struct packed {
        logic [SB_AW-3:0] waddr;
        logic [31:0]      data;
        logic             valid;
    } sb_entry_t;

    // Word address of a 32-bit byte address.
    function automatic logic [SB_AW-3:0] sb_word_addr(input logic [31:0] byte_addr);
        return byte_addr[SB_AW-1:WORD_SHIFT];
    endfunction

endpackage

// File: rtl/sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Purpose : combinational youngest-first search of the store buffer.
//           Every valid entry whose word address equals key is a candidate;
//           the candidate closest to the tail (most recently written) wins.
// Ports   :
//   entries   in   DEPTH x sb_entry_t   buffer contents
//   head      in   PW                   index of the oldest entry
//   key       in   SB_AW-2              word address searched for
//   hit       out  1                    at least one valid entry matches
//   hit_data  out  32                   data of the youngest matching entry
//   hit_idx   out  PW                   index of the youngest matching entry
// -----------------------------------------------------------------------------
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]         head,
    input  logic [SB_AW-3:0]      key,
    output logic                  hit,
    output logic [31:0]           hit_data,
    output logic [PW-1:0]         hit_idx
);

    logic [DEPTH-1:0] match_vec;
    logic [PW-1:0]    scan_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match_vec[gi] = entries[gi].valid && (entries[gi].waddr == key);
        end
    endgenerate

    // Valid entries are contiguous starting at head, so walking from head in
    // age order and letting each later match override the earlier one leaves
    // the youngest match selected. Pointer arithmetic wraps because DEPTH is
    // a power of two.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if (match_vec[scan_idx]) begin
                hit      = 1'b1;
                hit_data = entries[scan_idx].data;
                hit_idx  = scan_idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Purpose : write buffer between the MEM stage and a word-addressed data
//           memory. Stores are queued in a circular FIFO and drained to memory
//           in cycles where the memory port is free; loads are forwarded from
//           the youngest matching buffered store, otherwise read from memory.
// Build option:
//   STORE_BUF_COALESCE_EN - when defined, a store whose word address matches a
//                           buffered entry overwrites the youngest such entry
//                           in place (no allocation, no stall even when full).
// Ports:
//   clk            in   1    rising-edge clock
//   rst            in   1    asynchronous active-high reset
//   cpu_addr       in   32   byte address from the MEM stage
//   cpu_wdata      in   32   store data
//   cpu_mem_read   in   1    load request
//   cpu_mem_write  in   1    store request (wins over a simultaneous load)
//   cpu_rdata      out  32   load data, combinational
//   stall          out  1    store refused this cycle (buffer full)
//   mem_addr       out  32   data memory address
//   mem_wdata      out  32   data memory write data
//   mem_read       out  1    data memory read enable
//   mem_write      out  1    data memory write enable
//   mem_rdata      in   32   data memory read data (asynchronous read)
//   empty          out  1    no buffered stores
//   count          out  clog2(DEPTH+1)  occupancy
// -----------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    input  logic                       cpu_mem_read,
    input  logic                       cpu_mem_write,
    output logic [31:0]                cpu_rdata,
    output logic                       stall,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic [31:0]                mem_rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

`ifdef STORE_BUF_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [SB_AW-3:0] cpu_waddr;
    logic             wr_req;
    logic             rd_req;
    logic             cpu_idle;
    logic             full;
    logic             hit;
    logic [31:0]      hit_data;
    logic [PW-1:0]    hit_idx;
    logic             coalesce;
    logic             stall_int;
    logic             accept;
    logic             load_hit;
    logic             load_miss;
    logic             drain;

    // Byte-lane bits never take part in the word-addressed search.
    logic unused_byte_lane;
    assign unused_byte_lane = ^cpu_addr[WORD_SHIFT-1:0];

    assign cpu_waddr = sb_word_addr(cpu_addr);

    // A simultaneous read and write is treated as a write only.
    assign wr_req   = cpu_mem_write;
    assign rd_req   = cpu_mem_read && !cpu_mem_write;
    assign cpu_idle = !cpu_mem_read && !cpu_mem_write;
    assign full     = (count_q == CW'(DEPTH));

    // The same matcher serves loads and (when coalescing) stores: in both
    // cases the key is the word address on the CPU port.
    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries  (entries_q),
        .head     (head_q),
        .key      (cpu_waddr),
        .hit      (hit),
        .hit_data (hit_data),
        .hit_idx  (hit_idx)
    );

    assign coalesce  = COALESCE_EN && wr_req && hit;
    assign stall_int = wr_req && full && !coalesce;
    assign accept    = wr_req && !full && !coalesce;
    assign load_hit  = rd_req && hit;
    assign load_miss = rd_req && !hit;

    // The memory port is free when the CPU does not use it: idle cycles,
    // forwarded loads and refused stores. A stall cycle always drains, which
    // guarantees the held store finds room on the following cycle.
    assign drain = (count_q != '0) && (cpu_idle || load_hit || stall_int);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // accept, coalesce and drain are mutually exclusive by construction, so
    // occupancy moves by at most one per cycle.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (accept) begin
            entries_d[tail_q].waddr = cpu_waddr;
            entries_d[tail_q].data  = cpu_wdata;
            entries_d[tail_q].valid = 1'b1;
            tail_d                  = tail_q + PW'(1);
            count_d                 = count_q + CW'(1);
        end

        if (coalesce) begin
            entries_d[hit_idx].data = cpu_wdata;
        end

        if (drain) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PW'(1);
            count_d                 = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall     = stall_int;
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign mem_write = drain;
    assign mem_read  = load_miss;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (drain) begin
            mem_addr  = {entries_q[head_q].waddr, 2'b00};
            mem_wdata = entries_q[head_q].data;
        end else if (load_miss) begin
            mem_addr  = cpu_addr;
        end
    end

    always_comb begin
        cpu_rdata = '0;
        if (load_hit) begin
            cpu_rdata = hit_data;
        end else if (load_miss) begin
            cpu_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed steps followed by a random run. The reference keeps the buffered
// stores as a plain queue (oldest first) and a word array standing for what
// memory should hold; expected outputs come from those using the buffer rules.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;

`ifdef STORE_BUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_mem_read = 1'b0;
    logic        cpu_mem_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .cpu_rdata     (cpu_rdata),
        .stall         (stall),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_rdata     (mem_rdata),
        .empty         (empty),
        .count         (count)
    );

    // Data memory: 32 words, asynchronous read, write on the rising edge.
    logic [31:0] dmem [0:31];
    assign mem_rdata = dmem[mem_addr[6:2]];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[6:2]] <= mem_wdata;
    end

    // Reference state
    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ref_mem [0:31];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle of CPU activity with all outputs checked mid-cycle.
    task automatic step(input logic r, input logic w, input logic [4:0] idx,
                        input logic [31:0] d, output logic stalled);
        int          hit_j;
        logic        rd, exp_hit, coal, exp_stall, exp_drain;
        logic [31:0] exp_rdata;
        @(negedge clk);
        cpu_mem_read  = r;
        cpu_mem_write = w;
        cpu_addr      = {25'd0, idx, 2'b00};
        cpu_wdata     = d;
        #1;
        rd    = r && !w;
        hit_j = -1;
        for (int j = 0; j < q.size(); j++) if (q[j].idx == idx) hit_j = j;
        exp_hit   = (hit_j >= 0);
        coal      = COAL && w && exp_hit;
        exp_stall = w && (q.size() == DEPTH) && !coal;
        exp_drain = (q.size() > 0) && ((!r && !w) || (rd && exp_hit) || exp_stall);
        exp_rdata = !rd ? 32'd0 : (exp_hit ? q[hit_j].data : ref_mem[idx]);

        check("stall",     {31'd0, stall},     {31'd0, exp_stall});
        check("mem_write", {31'd0, mem_write}, {31'd0, exp_drain});
        check("mem_read",  {31'd0, mem_read},  {31'd0, rd && !exp_hit});
        check("cpu_rdata", cpu_rdata, exp_rdata);
        check("count",     {29'd0, count},     32'(q.size()));
        check("empty",     {31'd0, empty},     {31'd0, q.size() == 0});
        if (exp_drain) begin
            check("drain_addr",  mem_addr,  {25'd0, q[0].idx, 2'b00});
            check("drain_wdata", mem_wdata, q[0].data);
        end else if (rd && !exp_hit) begin
            check("miss_addr", mem_addr, cpu_addr);
        end
        $display("[TB] t=%0t rd=%0b wr=%0b addr=%h wdata=%h rdata=%h stall=%0b mwr=%0b count=%0d",
                 $time, r, w, cpu_addr, d, cpu_rdata, stall, mem_write, count);

        @(posedge clk);
        if (exp_drain) begin
            ref_mem[q[0].idx] = q[0].data;
            void'(q.pop_front());
        end
        if (coal) q[hit_j].data = d;
        else if (w && !exp_stall) q.push_back('{idx: idx, data: d});
        stalled = exp_stall;
    endtask

    // A store the pipeline keeps presenting until it is accepted.
    task automatic store_hold(input logic r, input logic [4:0] idx, input logic [31:0] d);
        logic st;
        for (int k = 0; k < 2; k++) begin
            step(r, 1'b1, idx, d, st);
            if (!st) return;
        end
    endtask

    task automatic idle(input int n);
        logic st;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 5'd0, 32'd0, st);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic st;
        int   op;
        for (int i = 0; i < 32; i++) begin
            dmem[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty",     {31'd0, empty},     32'd1);
        check("rst_stall",     {31'd0, stall},     32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_read",  {31'd0, mem_read},  32'd0);
        check("rst_cpu_rdata", cpu_rdata,          32'd0);
        check("rst_count",     {29'd0, count},     32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load miss on an empty buffer
        step(1'b1, 1'b0, 5'd4, 32'd0, st);

        // Store then idle: drains in the idle cycle
        store_hold(1'b0, 5'd2, 32'hDEADBEEF);
        idle(1);

        // Two stores to one word, load forwards the younger
        store_hold(1'b0, 5'd1, 32'h11);
        store_hold(1'b0, 5'd1, 32'h22);
        step(1'b1, 1'b0, 5'd1, 32'd0, st);
        idle(3);

        // Fill, then one more store meets a full buffer
        for (int i = 0; i < 4; i++) store_hold(1'b0, 5'(i), 32'h100 + 32'(i));
        store_hold(1'b0, 5'd4, 32'h104);

        // Store to an address already buffered while full
        store_hold(1'b0, 5'd1, 32'h55);
        idle(6);

        // Reset in the middle of a burst discards buffered stores
        for (int i = 0; i < 3; i++) store_hold(1'b0, 5'(8 + i), 32'hA0 + 32'(i));
        @(negedge clk);
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(5);

        // Random traffic over a small address window to provoke hits
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 2)      idle(1);
            else if (op <= 5) step(1'b1, 1'b0, 5'($urandom_range(0, 7)), 32'd0, st);
            else if (op <= 8) store_hold(1'b0, 5'($urandom_range(0, 7)), $urandom);
            else              store_hold(1'b1, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(DEPTH + 2);

        // Memory image after all stores drained
        for (int i = 0; i < 32; i++) check("mem_word", dmem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the MEM-stage memory interface and the word-addressed data memory (32 words, async read, write on posedge clk).
- Stores are queued in a small FIFO and drained to memory in cycles when the memory port is idle.
- Loads search the buffer youngest-first and are forwarded on a hit; on a miss they read memory directly.
- Removes store/load port contention from the pipeline. Stalls the pipeline only when a store meets a full buffer.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, 2..16.
- AW, 32: address width; the word address is addr[AW-1:2].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  32  byte address from the MEM stage
- cpu_wdata  in  32  store data
- cpu_mem_read  in  1  load request
- cpu_mem_write  in  1  store request
- cpu_rdata  out  32  load data (combinational)
- stall  out  1  store not accepted this cycle; the pipeline holds
- mem_addr  out  32  address to data memory
- mem_wdata  out  32  write data to data memory
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_rdata  in  32  data memory read data
- empty  out  1  buffer holds no stores
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset clears count, head and tail pointers, and entry valid bits. All registered state is 0 after reset.
- Combinational outputs after reset: empty=1, stall=0, mem_write=0, mem_read=0, cpu_rdata=0.
- Reset mid-operation discards buffered stores. They are never written to memory.
- Storage: entry = {word address [AW-1:2], data[31:0]}. Circular FIFO with head (oldest) and tail; pointers wrap modulo DEPTH.
- Read-and-write in the same cycle (both cpu_mem_read and cpu_mem_write high) is treated as a write only; cpu_rdata=0.
- Store accept:
  - Condition: cpu_mem_write=1 and count<DEPTH.
  - Effect: entry written at tail on posedge, tail+1, count+1.
  - The store is visible to loads from the next cycle.
  - No direct write-through to memory, even when the buffer is empty.
- Full handling:
  - stall = cpu_mem_write && count==DEPTH (combinational, same cycle).
  - During a stall cycle the head entry is force-drained, so count becomes DEPTH-1.
  - The held store is accepted the next cycle. Stall lasts exactly 1 cycle.
- Load forwarding:
  - cpu_mem_read=1: compare cpu_addr[AW-1:2] against all valid entries.
  - Multiple matches: the youngest entry (closest to tail) wins.
  - Hit: cpu_rdata = entry data, mem_read=0.
  - Miss: mem_read=1, mem_addr=cpu_addr, cpu_rdata=mem_rdata.
  - No load: cpu_rdata=0.
- Drain:
  - A drain happens when count>0 and one of the following holds:
    - (a) no CPU access this cycle;
    - (b) a load that hits;
    - (c) a stall cycle.
  - During a drain: mem_write=1, mem_addr={head addr,2'b00}, mem_wdata=head data. Memory captures the write on the same posedge. head+1, count-1.
  - No drain during an accepted store or a missing load; the port is reserved for the CPU.
- Ordering: stores drain strictly in FIFO order.
- A load that misses the buffer but whose address equals the entry draining that cycle cannot occur, because a miss load blocks drain.
- Concurrent accept and drain never happen in the same cycle, so count changes by at most ±1 per cycle.
- Latency:
  - Load: 0 cycles, combinational hit or miss.
  - Store reaches memory no earlier than the posedge at the end of the first idle cycle after acceptance.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined: a store whose word address matches a valid entry overwrites the youngest matching entry's data in place. count is unchanged and stall is 0, even when full.
- Undefined: every store allocates a new entry, as described in Behaviour.

Decomposition:
- Shared package holds:
  - WORD_SHIFT=2
  - DMEM_WORDS=32
  - the sb_entry_t struct {logic [AW-3:0] waddr; logic [31:0] data; logic valid}
- One sub-module: sb_match. Combinational youngest-first priority match over entries; outputs hit and the hit data.
- FIFO control remains in store_buffer.

Test Plan:
- Reset, then load at 0x10 → mem_read=1, cpu_rdata=mem_rdata (0), empty=1, count=0.
- Store 0x8 ← 0xDEADBEEF, then an idle cycle → count goes 1 then 0; mem_write=1 with addr 0x8 and data 0xDEADBEEF in the idle cycle.
- Stores 0x4 ← 0x11 then 0x4 ← 0x22, then load 0x4 → cpu_rdata=0x22, mem_read=0, and the head drains that cycle.
- Four back-to-back stores (0x0..0xC), then a fifth to 0x10 → stall=1 for one cycle, entry 0x0 drained that cycle, fifth accepted next cycle, count=4.
- Three stores, assert rst mid-stream for 1 cycle, then idle for 5 cycles → count=0, mem_write never asserted.
- With STORE_BUF_COALESCE_EN, fill to 4, then store 0x4 ← 0x55 → stall=0, count=4; later drain writes 0x55 to 0x4 exactly once.
